// File: rtl/kara_ctrl_pkg.sv
// Shared definitions for the Karatsuba multiplier arbiter.
//   OPND_W / PROD_W : operand and product widths.
//   MAX_REQ / MAX_ID_W : upper bound on requesters and the id width that covers it.
//   tag_t   : one stage of the in-flight tag pipeline {valid, id}.
//   rr_pick : round-robin search from ptr+1 (mod n) returning a one-hot grant.
package kara_ctrl_pkg;

    localparam int OPND_W   = 32;
    localparam int PROD_W   = 64;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    // Only the low n bits of valid are meaningful; the search never
    // looks beyond requester n-1.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_REQ-1:0]  grant;
        logic                found;
        int                  idx;
        logic [MAX_ID_W-1:0] sel;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            sel = idx[MAX_ID_W-1:0];
            if (k <= n && !found && valid[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/kara_mult_arbiter_if.sv
// Bus bundle between the requesters/consumer/multiplier and the arbiter.
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake
//   mul_a_o/mul_b_o/mul_c_i         : multiplier operands out, product in
//   rsp_valid/rsp_ready/rsp_id/rsp_data : response stream
// Handshake rule for both req and rsp: a transfer happens in a cycle where
// valid and ready are both high; valid may not depend on ready, the
// producer holds its payload stable until the transfer, and ready may be
// computed combinationally from valid.
interface kara_mult_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import kara_ctrl_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OPND_W-1:0] req_a;
    logic [NUM_REQ*OPND_W-1:0] req_b;
    logic [OPND_W-1:0]         mul_a_o;
    logic [OPND_W-1:0]         mul_b_o;
    logic [PROD_W-1:0]         mul_c_i;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [PROD_W-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, mul_c_i, rsp_ready,
        output req_ready, mul_a_o, mul_b_o, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, mul_c_i, rsp_ready,
        input  req_ready, mul_a_o, mul_b_o, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/kara_rsp_fifo.sv
// First-word-fall-through response FIFO.
//   push/push_data : write one entry (caller guarantees !full)
//   pop/pop_data   : pop_data shows the head entry; pop advances it
//                    (caller guarantees !empty)
//   empty/full     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module kara_rsp_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/kara_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency pipelined
// multiplier among NUM_REQ requesters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : kara_mult_arbiter_if.slave (requests, multiplier, responses)
//   stat_issue/stat_stall : only with KARA_ARB_STATS_EN defined
// Because the multiplier cannot stall, issue is gated by credits: `used`
// counts in-flight ops plus FIFO entries and never exceeds FIFO_DEPTH, so
// every product that emerges has a FIFO slot waiting for it.
module kara_mult_arbiter
    import kara_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MULT_LAT   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    kara_mult_arbiter_if.slave  bus
`ifdef KARA_ARB_STATS_EN
    ,
    output logic [31:0]         stat_issue,
    output logic [31:0]         stat_stall
`endif
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W = PROD_W + ID_W;

    logic [ID_W-1:0]     ptr;
    logic [CNT_W-1:0]    used;
    tag_t                tag_pipe [MULT_LAT+1];

    logic [MAX_REQ-1:0]  valid_ext;
    logic [MAX_REQ-1:0]  grant_ext;
    logic [MAX_ID_W-1:0] ptr_ext;
    logic [MAX_ID_W-1:0] gnt_idx;
    logic [OPND_W-1:0]   sel_a;
    logic [OPND_W-1:0]   sel_b;
    logic                credit_ok;
    logic                issue;
    logic                pop;

    logic                fifo_push;
    logic                fifo_empty;
    logic                fifo_full;
    logic [FIFO_W-1:0]   fifo_out;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = bus.req_valid;
        ptr_ext                  = '0;
        ptr_ext[ID_W-1:0]        = ptr;
        credit_ok                = (used < CNT_W'(FIFO_DEPTH));
        grant_ext                = credit_ok ? rr_pick(valid_ext, ptr_ext, NUM_REQ) : '0;
        // The grant only ever lands on a valid requester, so any grant bit
        // is a handshake.
        issue                    = |grant_ext;
        gnt_idx                  = '0;
        sel_a                    = '0;
        sel_b                    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_ext[i]) begin
                gnt_idx = MAX_ID_W'(i);
                sel_a   = bus.req_a[i*OPND_W +: OPND_W];
                sel_b   = bus.req_b[i*OPND_W +: OPND_W];
            end
        end
    end

    assign bus.req_ready = grant_ext[NUM_REQ-1:0];
    assign pop           = ~fifo_empty & bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= ID_W'(NUM_REQ - 1);
            used        <= '0;
            bus.mul_a_o <= '0;
            bus.mul_b_o <= '0;
        end else begin
            if (issue) begin
                ptr         <= gnt_idx[ID_W-1:0];
                bus.mul_a_o <= sel_a;
                bus.mul_b_o <= sel_b;
            end
            case ({issue, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    // Stage k holds the tag of the op whose operands reached the
    // multiplier k cycles ago; the last stage lines up with mul_c_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= MULT_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: issue, id: gnt_idx};
            for (int k = 1; k <= MULT_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    // Credits already prevent a push into a full FIFO; the full term only
    // keeps a corrupted credit count from overwriting live entries.
    assign fifo_push = tag_pipe[MULT_LAT].valid & ~fifo_full;

    kara_rsp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({tag_pipe[MULT_LAT].id[ID_W-1:0], bus.mul_c_i}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.rsp_valid = ~fifo_empty;
    assign bus.rsp_id    = fifo_empty ? '0 : fifo_out[FIFO_W-1 -: ID_W];
    assign bus.rsp_data  = fifo_empty ? '0 : fifo_out[PROD_W-1:0];

`ifdef KARA_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (issue) begin
                stat_issue <= stat_issue + 32'd1;
            end
            if ((|bus.req_valid) && !issue && (used == CNT_W'(FIFO_DEPTH))) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kara_mult_arbiter.sv
// Testbench for kara_mult_arbiter (optionally with KARA_ARB_STATS_EN).
// Contains a behavioural MULT_LAT-stage multiplier, a cycle model of the
// arbiter/credit/FIFO timing, a scoreboard queue of {id, product}, and a
// linear sequence of directed steps.
module tb_kara_mult_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int MULT_LAT   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = $clog2(NUM_REQ);
    localparam int EXP_W      = ID_W + 64;

    logic clk;
    logic rst;

    kara_mult_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef KARA_ARB_STATS_EN
    logic [31:0] stat_issue;
    logic [31:0] stat_stall;
`endif

    kara_mult_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MULT_LAT   (MULT_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef KARA_ARB_STATS_EN
        ,
        .stat_issue (stat_issue),
        .stat_stall (stat_stall)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- multiplier model ----------------
    logic [63:0] mpipe [MULT_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MULT_LAT; k++) mpipe[k] <= '0;
        end else begin
            mpipe[0] <= {32'b0, bus.mul_a_o} * {32'b0, bus.mul_b_o};
            for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign bus.mul_c_i = mpipe[MULT_LAT-1];

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [31:0] op_a [NUM_REQ];
    logic [31:0] op_b [NUM_REQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int rr_model(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i] = a;
        op_b[i] = b;
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Issue one op from requester i alone and time its response.
    task automatic single_op(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp_p, input string tag);
        logic [NUM_REQ-1:0] v;
        bit granted;
        bit seen;
        int lat;
        set_op(i, a, b);
        v = '0;
        v[i] = 1'b1;
        bus.req_valid = v;
        granted = 1'b0;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            if (bus.req_ready[i]) granted = 1'b1;
            else tick();
        end
        chk({tag, "_grant"}, 64'(granted), 64'd1);
        tick();
        bus.req_valid = '0;
        lat = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(MULT_LAT + 2));
        chk({tag, "_id"}, 64'(bus.rsp_id), 64'(i));
        chk({tag, "_data"}, bus.rsp_data, exp_p);
        tick();
        @(negedge clk);
        chk({tag, "_one_cycle"}, 64'(bus.rsp_valid), 64'd0);
        tick();
    endtask

    // ---------------- cycle model + scoreboard ----------------
    int          m_ptr;
    int          m_used;
    int          m_cnt;
    bit          m_tags [MULT_LAT+1];
    logic [31:0] m_mul_a;
    logic [31:0] m_mul_b;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_rdy;
        logic [EXP_W-1:0]   e;
        int g;
        int arrive;
        int pop;
        if (rst) begin
            m_ptr   = NUM_REQ - 1;
            m_used  = 0;
            m_cnt   = 0;
            m_mul_a = '0;
            m_mul_b = '0;
            for (int k = 0; k <= MULT_LAT; k++) m_tags[k] = 1'b0;
            exp_q.delete();
        end else begin
            exp_rdy = '0;
            g = -1;
            if (m_used < FIFO_DEPTH) g = rr_model(bus.req_valid, m_ptr);
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_cnt != 0));
            chk("mul_a", 64'(bus.mul_a_o), 64'(m_mul_a));
            chk("mul_b", 64'(bus.mul_b_o), 64'(m_mul_b));
            if (!bus.rsp_valid) begin
                chk("idle_id", 64'(bus.rsp_id), 64'd0);
                chk("idle_data", bus.rsp_data, 64'd0);
            end else if (bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e[EXP_W-1 -: ID_W]));
                    chk("rsp_data", bus.rsp_data, e[63:0]);
                end
            end
            if (|(bus.req_valid & bus.req_ready)) hs_count++;
            pop    = (m_cnt != 0 && bus.rsp_ready) ? 1 : 0;
            arrive = m_tags[MULT_LAT] ? 1 : 0;
            for (int k = MULT_LAT; k > 0; k--) m_tags[k] = m_tags[k-1];
            m_tags[0] = (g >= 0);
            if (g >= 0) begin
                m_ptr   = g;
                m_mul_a = op_a[g];
                m_mul_b = op_b[g];
                exp_q.push_back({ID_W'(g), prod(op_a[g], op_b[g])});
            end
            m_cnt  = m_cnt + arrive - pop;
            m_used = m_used + ((g >= 0) ? 1 : 0) - pop;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int g;
        int nxt;
        int h0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_mul_a", 64'(bus.mul_a_o), 64'd0);
        chk("rst_mul_b", 64'(bus.mul_b_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
`ifdef KARA_ARB_STATS_EN
        chk("rst_stat_issue", 64'(stat_issue), 64'd0);
        chk("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif
        tick();

        // Single request and operand corners
        bus.rsp_ready = 1'b1;
        single_op(0, 32'd3, 32'd5, 64'd15, "single");
        single_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_ops");
        single_op(1, 32'd0, 32'hDEAD_BEEF, 64'd0, "zero_op");
        drain();

        // Fairness with all requesters active
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom, $urandom_range(32'hFFFF, 0));
        bus.req_valid = '1;
        nxt = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            g = -1;
            for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) g = i;
            if (k < NUM_REQ) chk("fair_first", 64'(bus.req_ready), 64'd1 << k);
            if (g >= 0) begin
                chk("fair_order", 64'(g), 64'(nxt));
                nxt = (nxt + 1) % NUM_REQ;
            end
            tick();
            if (g >= 0) set_op(g, $urandom, $urandom);
        end
        bus.req_valid = '0;
        drain();

        // Backpressure: credits run out, then one pop frees one issue
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom, $urandom);
        bus.req_valid = '1;
        h0 = hs_count;
        repeat (10) tick();
        chk("bp_issues", 64'(hs_count - h0), 64'(FIFO_DEPTH));
        @(negedge clk);
        chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
`ifdef KARA_ARB_STATS_EN
        chk("bp_stat_issue", 64'(stat_issue), 64'd4);
        chk("bp_stat_stall", 64'(stat_stall), 64'd6);
`endif
        tick();
        bus.rsp_ready = 1'b1;
        h0 = hs_count;
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("bp_pulse_issues", 64'(hs_count - h0), 64'd1);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        drain();

        // Stats cleared by reset
        do_reset();
`ifdef KARA_ARB_STATS_EN
        @(negedge clk);
        chk("clr_stat_issue", 64'(stat_issue), 64'd0);
        chk("clr_stat_stall", 64'(stat_stall), 64'd0);
        tick();
`endif

        // Reset while two ops are in flight
        set_op(0, $urandom, $urandom);
        set_op(1, $urandom, $urandom);
        bus.req_valid = 4'b0011;
        h0 = hs_count;
        for (int k = 0; k < 10 && (hs_count - h0) < 2; k++) begin
            @(negedge clk);
            tick();
        end
        chk("mid_two_issued", 64'(hs_count - h0), 64'd2);
        bus.req_valid = '0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("mid_rsp_quiet", 64'(bus.rsp_valid), 64'd0);
            tick();
        end
        for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom, $urandom);
        bus.req_valid = '1;
        @(negedge clk);
        chk("mid_first_grant", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
